// File: rtl/t9990_clken_gen.sv
// T9990 clock-enable and memory-slot generator: 12-phase frame at 85.909 MHz.
// Optional ~25.175 MHz phase accumulator enabled by macro T9990_CLKEN_25M_EN.
module t9990_clken_gen #(
  parameter int INC_25M          = 19205,
  parameter int ACC_W            = 16,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic       CLK,
  input  logic       RESET_n,
  output logic       CLK_21M_EN,
  output logic       CLK_14M_EN,
  output logic       CLK_25M_EN,
  output logic       RAM_REQ,
  output logic [1:0] RAM_SLOT,
  output logic       REFRESH_REQ
);

  localparam int FCNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(REFRESH_INTERVAL - 1);

  logic [3:0]        phase_q, phase_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              en21_q, en21_d;
  logic              en14_q, en14_d;
  logic              ram_q, ram_d;
  logic [1:0]        slot_q, slot_d;
  logic              refr_q, refr_d;

  // Outputs are registered from the next-phase decode so they line up with PHASE.
  always_comb begin
    phase_d = (phase_q == 4'd11) ? '0 : phase_q + 4'd1;
    fcnt_d  = fcnt_q;
    if (phase_q == 4'd11) begin
      fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FCNT_W'(1);
    end

    en21_d = (phase_d == 4'd0) || (phase_d == 4'd4) || (phase_d == 4'd8);
    en14_d = (phase_d == 4'd0) || (phase_d == 4'd6);
    refr_d = (phase_d == 4'd10) && (fcnt_d == FCNT_LAST);
    ram_d  = '0;
    slot_d = '0;
    unique case (phase_d)
      4'd2:    ram_d = 1'b1;
      4'd6:    begin ram_d = 1'b1; slot_d = 2'd1; end
      4'd10:   if (!refr_d) begin ram_d = 1'b1; slot_d = 2'd2; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      phase_q <= '0;
      fcnt_q  <= '0;
      en21_q  <= '0;
      en14_q  <= '0;
      ram_q   <= '0;
      slot_q  <= '0;
      refr_q  <= '0;
    end else begin
      phase_q <= phase_d;
      fcnt_q  <= fcnt_d;
      en21_q  <= en21_d;
      en14_q  <= en14_d;
      ram_q   <= ram_d;
      slot_q  <= slot_d;
      refr_q  <= refr_d;
    end
  end

  assign CLK_21M_EN  = en21_q;
  assign CLK_14M_EN  = en14_q;
  assign RAM_REQ     = ram_q;
  assign RAM_SLOT    = slot_q;
  assign REFRESH_REQ = refr_q;

`ifdef T9990_CLKEN_25M_EN
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   acc_sum;
  logic             en25_q;

  // Free-running; the carry is deliberately not aligned to the frame.
  always_comb begin
    acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(INC_25M);
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      acc_q  <= '0;
      en25_q <= '0;
    end else begin
      acc_q  <= acc_sum[ACC_W-1:0];
      en25_q <= acc_sum[ACC_W];
    end
  end

  assign CLK_25M_EN = en25_q;
`else
  // Constant low; the parameters are referenced only to keep them in use.
  assign CLK_25M_EN = 1'b0 & (ACC_W != 0) & (INC_25M != 0);
`endif

endmodule

// File: tb/tb_t9990_clken_gen.sv
// Scoreboard bench for t9990_clken_gen: frame-arithmetic reference model,
// randomized mid-frame resets; honours T9990_CLKEN_25M_EN for the 25 MHz model.
`timescale 1ns/1ps
module tb_t9990_clken_gen;

  localparam int RI       = 4;
  localparam int INC      = 19205;
  localparam int AW       = 16;
  localparam int LONG_RUN = 65536;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       e21, e14, e25, ram, refr;
  logic [1:0] slot;

  always #5 CLK = ~CLK;

  t9990_clken_gen #(
    .INC_25M(INC),
    .ACC_W(AW),
    .REFRESH_INTERVAL(RI)
  ) dut (
    .CLK(CLK),
    .RESET_n(RESET_n),
    .CLK_21M_EN(e21),
    .CLK_14M_EN(e14),
    .CLK_25M_EN(e25),
    .RAM_REQ(ram),
    .RAM_SLOT(slot),
    .REFRESH_REQ(refr)
  );

  typedef struct {
    int       n;
    int       tag;
    bit       rst;
    bit       e21, e14, e25, ram, refr;
    bit [1:0] slot;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc_n = 0;
  int   cur_tag = 0;

  int   overlap_cnt = 0;
  int   rule_viol = 0;
  int   adj_cnt = 0;
  int   ram96 = 0;
  int   p25_cnt = 0;
  int   ref_pos[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference: position in the frame and frame number derived from the
  // number of clock edges since reset release.
  function automatic exp_t model(input int n, input int tg);
    exp_t e;
    int ph, fc, idx;
`ifdef T9990_CLKEN_25M_EN
    longint a, b;
`endif
    e.n = n; e.tag = tg; e.rst = 1'b0;
    e.e21 = 0; e.e14 = 0; e.e25 = 0; e.ram = 0; e.refr = 0; e.slot = 2'd0;
    if (n == 0) return e;
    ph = n % 12;
    fc = (n / 12) % RI;
    e.e21 = (ph % 4 == 0);
    e.e14 = (ph % 6 == 0);
    if (ph % 4 == 2) begin
      idx = ph / 4;
      if (idx == 2 && fc == RI - 1) e.refr = 1'b1;
      else begin
        e.ram  = 1'b1;
        e.slot = 2'(idx);
      end
    end
`ifdef T9990_CLKEN_25M_EN
    a = longint'(n) * INC;
    b = longint'(n - 1) * INC;
    e.e25 = ((a >> AW) != (b >> AW));
`endif
    return e;
  endfunction

  function automatic exp_t rst_entry();
    exp_t e;
    e = model(0, cur_tag);
    e.rst = 1'b1;
    return e;
  endfunction

  task automatic step(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(posedge CLK);
      cyc_n++;
      sbq.push_back(model(cyc_n, cur_tag));
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {e21, e14, e25, ram, refr, slot}, 0);
  endtask

  task automatic rst_pulse(input int dly, input int hold, input string name);
    @(negedge CLK);
    #(dly) RESET_n = 1'b0;
    #1 check_zero(name);
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      sbq.push_back(rst_entry());
    end
    @(negedge CLK);
    #2 RESET_n = 1'b1;
    cyc_n = 0;
  endtask

  initial begin : monitor
    exp_t e;
    bit   h1, h2, p21, p14, p25;
    logic [6:0] act, req;
    h1 = 0; h2 = 0; p21 = 0; p14 = 0; p25 = 0;
    forever begin
      @(negedge CLK);
      if (sbq.size() != 0) begin
        e   = sbq.pop_front();
        act = {e21, e14, e25, ram, refr, slot};
        req = {e.e21, e.e14, e.e25, e.ram, e.refr, e.slot};
        checks++;
        if (act === req) passed++;
        else $display("FAIL outputs tag=%0d n=%0d rst=%0d: got %b expected %b (21M,14M,25M,RAM,REF,SLOT)",
                      e.tag, e.n, e.rst, act, req);
        if (e.rst) begin
          h1 = 0; h2 = 0; p21 = 0; p14 = 0; p25 = 0;
        end else begin
          if (ram && refr) overlap_cnt++;
          if (e.n > 2 && ram && slot < 2'd2 && !h2) rule_viol++;
          if ((e21 && p21) || (e14 && p14) || (e25 && p25)) adj_cnt++;
          if (e.tag == 1 && e.n <= 96) begin
            if (ram) ram96++;
            if (refr) ref_pos.push_back(e.n);
          end
          if (e.tag == 1 && e.n <= LONG_RUN && e25) p25_cnt++;
          h2 = h1; h1 = e21;
          p21 = e21; p14 = e14; p25 = e25;
        end
      end
    end
  end

  initial begin : driver
    RESET_n = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      sbq.push_back(rst_entry());
    end
    @(negedge CLK);
    #1 check_zero("reset_state");
    #1 RESET_n = 1'b1;
    cyc_n = 0;

    // Edge 31 lands on PHASE 7 of frame 2.
    cur_tag = 2;
    step(31);
    rst_pulse(2, 1, "async_reset_mid_frame");

    cur_tag = 1;
    step(LONG_RUN + 4);

    cur_tag = 3;
    for (int k = 0; k < 6; k++) begin
      step(int'($urandom_range(1, 200)));
      rst_pulse(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), "async_reset_random");
    end

    cur_tag = 0;
    step(30);
    repeat (3) @(negedge CLK);
    #1;

    check("scoreboard_drained", sbq.size(), 0);
    check("ram_refresh_overlap", overlap_cnt, 0);
    check("ram_slot01_after_21m", rule_viol, 0);
    check("adjacent_enables", adj_cnt, 0);
    check("ram_req_in_96", ram96, 22);
    check("refresh_count_in_96", ref_pos.size(), 2);
    check("refresh_pos0", (ref_pos.size() > 0) ? ref_pos[0] : -1, 46);
    check("refresh_pos1", (ref_pos.size() > 1) ? ref_pos[1] : -1, 94);
`ifdef T9990_CLKEN_25M_EN
    check("clk25_pulses_65536", p25_cnt, 19205);
`else
    check("clk25_pulses_65536", p25_cnt, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/t9990_clken_gen.md
T9990_CLKEN_GEN -- requirements
Module: t9990_clken_gen

Interface
REQ-001 SHALL have parameter INC_25M, default 19205, 25.175 MHz phase-accumulator increment (ACC_W-bit), for CLK = 85.909 MHz.
REQ-002 SHALL have parameter ACC_W, default 16, phase-accumulator width in bits.
REQ-003 SHALL have parameter REFRESH_INTERVAL, default 64, number of 12-cycle frames between refresh slots (range 1..1024).
REQ-004 SHALL have port CLK  input  1  system clock, 85.909 MHz nominal (4 x 21.477 MHz).
REQ-005 SHALL have port RESET_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port CLK_21M_EN  output  1  21.477 MHz clock-enable pulse.
REQ-007 SHALL have port CLK_14M_EN  output  1  14.318 MHz clock-enable pulse.
REQ-008 SHALL have port CLK_25M_EN  output  1  ~25.175 MHz clock-enable pulse.
REQ-009 SHALL have port RAM_REQ  output  1  memory access slot strobe.
REQ-010 SHALL have port RAM_SLOT  output  2  slot index valid while RAM_REQ=1 (0, 1, 2).
REQ-011 SHALL have port REFRESH_REQ  output  1  refresh slot strobe, replaces one RAM_REQ.

Function
REQ-012 SHALL keep a 4-bit frame phase counter PHASE that counts 0..11 and wraps 11->0 on every CLK edge.
REQ-013 SHALL drive all outputs from flops; outputs SHALL reflect the PHASE value of the same cycle, meaning the flop loads the decode of next-PHASE.
REQ-014 CLK_21M_EN SHALL be 1 exactly when PHASE is 0, 4 or 8.
REQ-015 CLK_14M_EN SHALL be 1 exactly when PHASE is 0 or 6.
REQ-016 RAM_REQ SHALL be 1 when PHASE is 2, 6 or 10, with RAM_SLOT 0, 1 or 2 respectively. This places RAM_REQ exactly 2 CLK after each CLK_21M_EN, and after the PHASE-0 CLK_14M_EN.
REQ-017 RAM_SLOT SHALL be 0 whenever RAM_REQ=0.
REQ-018 SHALL keep a frame counter FCNT that increments at PHASE 11 and wraps from REFRESH_INTERVAL-1 to 0.
REQ-019 At PHASE 10 of the frame in which FCNT==REFRESH_INTERVAL-1, REFRESH_REQ SHALL be 1 and RAM_REQ SHALL be 0. RAM_REQ and REFRESH_REQ SHALL never both be 1.
REQ-020 Slots at PHASE 2 and 6 SHALL never be replaced by refresh. This guarantees a CLK_21M_EN/RAM_REQ and a CLK_14M_EN/RAM_REQ 2-cycle coincidence in every frame.
REQ-021 With REFRESH_INTERVAL=1, every frame's PHASE-10 slot SHALL be a refresh slot.
REQ-022 Each enable SHALL be a single-cycle pulse; no enable SHALL be high in two consecutive cycles.

Reset
REQ-023 RESET_n low SHALL asynchronously force PHASE=0, FCNT=0, the accumulator to 0 and every output to 0.
REQ-024 The first CLK edge after release SHALL move PHASE to 1. The first CLK_21M_EN SHALL then occur at PHASE 4, the first RAM_REQ at PHASE 2, and the first CLK_14M_EN at PHASE 6.
REQ-025 Reset asserted mid-frame or mid-refresh-interval SHALL discard all state; no partial pulse SHALL appear after release.

Configuration
REQ-026 Macro T9990_CLKEN_25M_EN: when defined, an ACC_W-bit accumulator SHALL add INC_25M every CLK (modulo 2^ACC_W). CLK_25M_EN SHALL be 1 in the cycle after each carry-out, i.e. registered.
REQ-027 When T9990_CLKEN_25M_EN is undefined, there SHALL be no accumulator logic, and CLK_25M_EN SHALL be constant 0.
REQ-028 The accumulator SHALL be independent of PHASE. Its carry SHALL not be resynchronised to the frame.

Verification
REQ-029 Reset then release, run 24 CLK -> CLK_21M_EN at edges 4, 8, 12, 16, 20, 24. CLK_14M_EN at 6, 12, 18, 24. RAM_REQ at 2, 6, 10, 14, 18, 22 with RAM_SLOT 0, 1, 2, 0, 1, 2.
REQ-030 REFRESH_INTERVAL=4, run 96 CLK -> REFRESH_REQ only at PHASE 10 of frames 3 and 7 (CLK 46, 94). RAM_REQ=0 in those cycles. 22 RAM_REQ pulses total.
REQ-031 Check every cycle for 10000 CLK -> each RAM_REQ with slot 0 or 1 is preceded 2 CLK earlier by CLK_21M_EN=1. The RAM_REQ/REFRESH_REQ overlap count is 0.
REQ-032 T9990_CLKEN_25M_EN defined, default INC_25M, run 65536 CLK -> exactly 19205 CLK_25M_EN pulses, none adjacent. Undefined -> 0 pulses.
REQ-033 Assert RESET_n low for 1 cycle at PHASE 7 of frame 2 -> all outputs 0 immediately. After release, the sequence repeats REQ-029 exactly.
